// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // RV32I load/store width codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte address where the optional preload image starts
  localparam int unsigned PRELOAD_BASE = 32'h0001_0000;

  // Preload image (contents of data.hex)
  localparam int unsigned PRELOAD_WORDS = 1;
  localparam logic [31:0] PRELOAD_IMAGE [PRELOAD_WORDS] = '{32'h0000_0007};

  // Initial wait-counter value for a given latency (unused when latency is 0)
  function automatic logic [3:0] lat_to_count(input int unsigned lat);
    return (lat == 0) ? 4'd0 : 4'(lat - 1);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for RV32I byte/half/word loads and stores.
// Produces byte enables, the replicated store word, the extended load value
// and a single error flag (misalignment or illegal funct3). On error the
// enables and load data are forced to zero.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = rword_i[{addr_lo_i, 3'b000} +: 8];
    assign sel_half = rword_i[{addr_lo_i[1], 4'b0000} +: 16];

    // Decode width/sign and alignment into enables, store word and load data
    always_comb begin
        be_o    = '0;
        wword_o = '0;
        rdata_o = '0;
        err_o   = 1'b0;
        unique case (funct3_i)
            F3_B: begin
                if (we_i) begin
                    be_o    = 4'b0001 << addr_lo_i;
                    wword_o = {4{wdata_i[7:0]}};
                end else begin
                    rdata_o = {{24{sel_byte[7]}}, sel_byte};
                end
            end
            F3_H: begin
                if (addr_lo_i[0]) begin
                    err_o = 1'b1;
                end else if (we_i) begin
                    be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    wword_o = {2{wdata_i[15:0]}};
                end else begin
                    rdata_o = {{16{sel_half[15]}}, sel_half};
                end
            end
            F3_W: begin
                if (addr_lo_i != 2'b00) begin
                    err_o = 1'b1;
                end else if (we_i) begin
                    be_o    = 4'b1111;
                    wword_o = wdata_i;
                end else begin
                    rdata_o = rword_i;
                end
            end
            F3_BU: begin
                if (we_i) err_o = 1'b1;
                else      rdata_o = {24'd0, sel_byte};
            end
            F3_HU: begin
                if (we_i || addr_lo_i[0]) err_o = 1'b1;
                else                      rdata_o = {16'd0, sel_half};
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle valid/ready data memory responder for the M-stage load/store port.
// One request in flight; RAM committed on the edge that enters RESP.
// Optional build macro: DMEM_PRELOAD_EN (preload image at byte 0x10000).
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 17,
  parameter int unsigned LATENCY       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err
);

  localparam int unsigned WORDS    = 1 << (ADDRESS_WIDTH - 2);
  localparam logic [3:0]  CNT_INIT = lat_to_count(LATENCY);

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  initial begin
    for (int unsigned i = 0; i < WORDS; i++) mem[i] = '0;
`ifdef DMEM_PRELOAD_EN
    for (int unsigned i = 0; i < PRELOAD_WORDS; i++) begin
      if ((PRELOAD_BASE >> 2) + i < WORDS) mem[(PRELOAD_BASE >> 2) + i] = PRELOAD_IMAGE[i];
    end
`endif
  end

  logic                     accept;
  logic                     enter_resp;
  logic                     op_we;
  logic [2:0]               op_f3;
  logic [ADDRESS_WIDTH-1:0] op_addr;
  logic [DATA_WIDTH-1:0]    op_wdata;
  logic [DATA_WIDTH-1:0]    rword;
  logic [3:0]               la_be;
  logic [DATA_WIDTH-1:0]    la_wword;
  logic [DATA_WIDTH-1:0]    la_rdata;
  logic                     la_err;

  assign accept     = (state_q == IDLE) && req_valid;
  assign enter_resp = rst && (((LATENCY == 0) && accept) || ((state_q == WAIT) && (cnt_q == 4'd0)));

  // With zero latency the access happens on the accept edge, so the live
  // request feeds the datapath instead of the (not yet loaded) capture regs.
  assign op_we    = (state_q == IDLE) ? req_we     : we_q;
  assign op_f3    = (state_q == IDLE) ? req_funct3 : f3_q;
  assign op_addr  = (state_q == IDLE) ? req_addr   : addr_q;
  assign op_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;
  assign rword    = mem[op_addr[ADDRESS_WIDTH-1:2]];

  dmem_lane_align u_align (
    .we_i      (op_we),
    .funct3_i  (op_f3),
    .addr_lo_i (op_addr[1:0]),
    .wdata_i   (op_wdata),
    .rword_i   (rword),
    .be_o      (la_be),
    .wword_o   (la_wword),
    .rdata_o   (la_rdata),
    .err_o     (la_err)
  );

  // Next-state, wait counter and response data selection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = (LATENCY == 0) ? RESP : WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      rdata_d = la_rdata;
      err_d   = la_err;
    end
  end

  // FSM, counter, request capture and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Byte-lane RAM write on the edge entering RESP; contents survive reset
  always_ff @(posedge clk) begin
    if (enter_resp && op_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (la_be[i]) mem[op_addr[ADDRESS_WIDTH-1:2]][8*i +: 8] <= la_wword[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a driver issues requests and pushes
// expected responses computed from a byte-addressed reference memory; a
// monitor pops and compares on each response handshake.
module tb_data_mem_responder;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [16:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    data_mem_responder #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (17),
        .LATENCY       (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          handshakes = 0;
    logic [7:0]  mdl [int];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end
    endfunction

    function automatic logic [7:0] rd_byte(input int a);
        return mdl.exists(a) ? mdl[a] : 8'h00;
    endfunction

    // Reference: RV32I access rules over a flat little-endian byte memory
    function automatic void ref_model(input logic we, input logic [2:0] f3, input int a,
                                      input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int          size;
        bit          sgn;
        bit          legal;
        logic [31:0] v;
        size = 1; sgn = 0; legal = 1; rd = '0;
        if (we) begin
            case (f3)
                3'd0: size = 1;
                3'd1: size = 2;
                3'd2: size = 4;
                default: legal = 0;
            endcase
        end else begin
            case (f3)
                3'd0: begin size = 1; sgn = 1; end
                3'd1: begin size = 2; sgn = 1; end
                3'd2: size = 4;
                3'd4: size = 1;
                3'd5: size = 2;
                default: legal = 0;
            endcase
        end
        err = !legal || ((a % size) != 0);
        if (err) return;
        if (we) begin
            for (int i = 0; i < size; i++) mdl[a + i] = wd[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < size; i++) v = v | (32'(rd_byte(a + i)) << (8 * i));
            if (sgn && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
            rd = v;
        end
    endfunction

    // Monitor: latency, hold-under-backpressure, response data, return to idle
    logic        pv_stall = 1'b0;
    logic        was_valid = 1'b0;
    logic        chk_idle = 1'b0;
    logic [31:0] p_rd = '0;
    logic        p_err = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            pv_stall  = 1'b0;
            was_valid = 1'b0;
            chk_idle  = 1'b0;
        end else begin
            if (chk_idle) begin
                check("idle_after_rsp", 32'(req_ready), 32'd1);
                chk_idle = 1'b0;
            end
            if (pv_stall) begin
                check("hold_valid", 32'(rsp_valid), 32'd1);
                check("hold_rdata", rsp_rdata, p_rd);
                check("hold_err", 32'(rsp_err), 32'(p_err));
            end
            if (rsp_valid) begin
                check("req_ready_in_rsp", 32'(req_ready), 32'd0);
                if (!was_valid) begin
                    if (q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
                    end else begin
                        check("latency", 32'(cyc - q[0].acc), 32'(LAT + 1));
                    end
                end
                if (rsp_ready) begin
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                    end
                    handshakes++;
                    chk_idle = 1'b1;
                end
            end
            pv_stall  = rsp_valid && !rsp_ready;
            p_rd      = rsp_rdata;
            p_err     = rsp_err;
            was_valid = rsp_valid;
        end
    end

    // Drive a request until accepted; optionally record the expected response
    task automatic issue(input logic we, input logic [2:0] f3, input logic [16:0] a,
                         input logic [31:0] wd, input bit expect_rsp);
        int   w;
        exp_t e;
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1");
            req_valid = 1'b0;
            return;
        end
        if (expect_rsp) begin
            ref_model(we, f3, int'(a), wd, e.rdata, e.err);
            e.acc = cyc;
            q.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Consume one response, holding rsp_ready low for 'stall' valid cycles
    task automatic finish_rsp(input int stall);
        int target;
        int held;
        int w;
        target = handshakes + 1;
        held = 0; w = 0;
        rsp_ready = (stall == 0);
        while (handshakes < target && w < 200) begin
            if (rsp_valid) begin
                if (held >= stall) rsp_ready = 1'b1;
                else held++;
            end
            @(posedge clk); #1; w++;
        end
        if (handshakes < target) begin
            checks++; failures++;
            $display("FAIL rsp_timeout: got no handshake expected one");
        end
        rsp_ready = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [16:0] a,
                          input logic [31:0] wd, input int stall);
        issue(we, f3, a, wd, 1'b1);
        finish_rsp(stall);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    initial begin
        int w;
`ifdef DMEM_PRELOAD_EN
        mdl[32'h10000] = 8'h07;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Word store/load
        do_req(1'b1, 3'b010, 17'h100, 32'hDEADBEEF, 0);
        do_req(1'b0, 3'b010, 17'h100, 32'h0, 0);
        // Byte store and signed/unsigned byte loads
        do_req(1'b1, 3'b000, 17'h103, 32'h12345680, 0);
        do_req(1'b0, 3'b000, 17'h103, 32'h0, 0);
        do_req(1'b0, 3'b100, 17'h103, 32'h0, 1);
        do_req(1'b0, 3'b010, 17'h100, 32'h0, 0);
        // Misaligned half store, unchanged word, illegal load funct3
        do_req(1'b1, 3'b001, 17'h101, 32'h00001234, 0);
        do_req(1'b0, 3'b010, 17'h100, 32'h0, 0);
        do_req(1'b0, 3'b011, 17'h100, 32'h0, 0);
        do_req(1'b0, 3'b101, 17'h102, 32'h0, 2);
        // Backpressure for 5 cycles
        do_req(1'b0, 3'b010, 17'h100, 32'h0, 5);

        // Reset during WAIT: store dropped, rsp_rdata (nonzero) cleared
        do_req(1'b1, 3'b010, 17'h200, 32'h11223344, 0);
        do_req(1'b0, 3'b010, 17'h200, 32'h0, 0);
        issue(1'b1, 3'b010, 17'h200, 32'h00000055, 1'b0);
        #2 rst = 1'b0;
        #1 check_reset_outputs("reset_wait");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, 3'b010, 17'h200, 32'h0, 0);

        // Reset during RESP: store already committed
        issue(1'b1, 3'b010, 17'h204, 32'hA5A5A5A5, 1'b1);
        w = 0;
        while (!rsp_valid && w < 50) begin
            @(posedge clk); #1; w++;
        end
        check("resp_reached", 32'(rsp_valid), 32'd1);
        #2 rst = 1'b0;
        #1 check_reset_outputs("reset_resp");
        q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, 3'b010, 17'h204, 32'h0, 0);

        // Preload region (7 with DMEM_PRELOAD_EN, 0 otherwise)
        do_req(1'b0, 3'b010, 17'h10000, 32'h0, 0);

        // Random traffic in a small window to force address reuse
        for (int i = 0; i < 80; i++) begin
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   17'($urandom_range(0, 12'h3FF)), $urandom, $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            checks++; failures++;
            $display("FAIL leftover_expected: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
